// File: rtl/parallel_to_serial_if.sv
// Word-in / byte-out handshake bundle for parallel_to_serial.
//   rx_valid, rx_bytes, rx_ready : upstream word handshake (N-bit word)
//   tx_byte, tx_valid, tx_ready  : downstream byte handshake toward the UART transmitter
//   done                         : one-cycle pulse after the last byte of a word is accepted
// master: the surroundings (word producer and byte consumer); slave: the converter itself.
interface parallel_to_serial_if #(
  parameter int unsigned N = 32
);
  logic         rx_valid;
  logic [N-1:0] rx_bytes;
  logic         rx_ready;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         done;

  modport master (
    output rx_valid, rx_bytes, tx_ready,
    input  rx_ready, tx_byte, tx_valid, done
  );

  modport slave (
    input  rx_valid, rx_bytes, tx_ready,
    output rx_ready, tx_byte, tx_valid, done
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Splits an N-bit word into bytes, most significant byte first, for the UART transmitter.
// An optional idle gap of GAP cycles follows every accepted byte except the last.
//   iCE_CLK : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : parallel_to_serial_if slave (word in, byte out, done pulse)
module parallel_to_serial #(
  parameter int unsigned N         = 32,
  parameter int unsigned Ndiv4log2 = 3,
  parameter int unsigned GAP       = 0
) (
  input logic                  iCE_CLK,
  input logic                  rst_n,
  parallel_to_serial_if.slave  bus
);

  localparam int unsigned NumBytes = N / 8;
  localparam int unsigned GapW     = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [Ndiv4log2-1:0] LastByte = Ndiv4log2'(NumBytes - 1);
  // Counts GAP-1 down to 0, so the gap state lasts exactly GAP cycles.
  localparam logic [GapW-1:0]      GapLoad  = GapW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]           state_q, state_d;
  logic [N-1:0]         shreg_q, shreg_d;
  logic [Ndiv4log2-1:0] byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.rx_valid) begin
          shreg_d    = bus.rx_bytes;
          byte_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (bus.tx_ready) begin
          shreg_d = shreg_q << 8;
          if (byte_cnt_q == LastByte) begin
            // Wrap rather than increment so the counter never exceeds the last index.
            byte_cnt_d = '0;
            state_d    = StIdle;
            done_d     = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + Ndiv4log2'(1);
            if (GAP > 0) begin
              gap_cnt_d = GapLoad;
              state_d   = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.rx_ready = (state_q == StIdle);
  assign bus.tx_valid = (state_q == StSend);
  // Zero after reset and after the last byte shifts out; only meaningful while tx_valid.
  assign bus.tx_byte  = shreg_q[N-1 -: 8];
  assign bus.done     = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench: two converters (GAP=0 and GAP=3) checked every cycle against a
// byte-count model, plus literal checks of the directed scenarios.
module tb_parallel_to_serial;
  localparam int unsigned N = 32;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc;

  parallel_to_serial_if #(.N(N)) bus0 ();
  parallel_to_serial_if #(.N(N)) bus3 ();

  parallel_to_serial #(.N(N), .Ndiv4log2(3), .GAP(0)) dut0 (
    .iCE_CLK (clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  parallel_to_serial #(.N(N), .Ndiv4log2(3), .GAP(3)) dut3 (
    .iCE_CLK (clk),
    .rst_n   (rst_n),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a word, how many of its bytes remain, and idle cycles left before the next byte.
  typedef struct {
    logic [N-1:0] word;
    int           remaining;
    int           gap_left;
    bit           done;
  } model_t;

  model_t m [2];

  function automatic model_t step(model_t s, int gap, logic rxv, logic [N-1:0] rxb,
                                  logic txr);
    model_t n = s;
    n.done = 1'b0;
    if (s.remaining == 0) begin
      if (rxv) begin
        n.word      = rxb;
        n.remaining = N / 8;
      end
    end else if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
    end else if (txr) begin
      n.remaining = s.remaining - 1;
      if (n.remaining == 0) n.done = 1'b1;
      else n.gap_left = gap;
    end
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.word      = '0;
    r.remaining = 0;
    r.gap_left  = 0;
    r.done      = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= model_reset();
      m[1] <= model_reset();
    end else begin
      m[0] <= step(m[0], 0, bus0.rx_valid, bus0.rx_bytes, bus0.tx_ready);
      m[1] <= step(m[1], 3, bus3.rx_valid, bus3.rx_bytes, bus3.tx_ready);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic rr, input logic tv, input logic [7:0] tb,
                          input logic dn);
    logic [N-1:0] sh;
    logic         exp_tv;
    exp_tv = (m[i].remaining > 0) && (m[i].gap_left == 0);
    check($sformatf("inst%0d rx_ready", i), 64'(rr), 64'(m[i].remaining == 0));
    check($sformatf("inst%0d tx_valid", i), 64'(tv), 64'(exp_tv));
    check($sformatf("inst%0d done", i), 64'(dn), 64'(m[i].done));
    if (exp_tv) begin
      sh = m[i].word >> (8 * (m[i].remaining - 1));
      check($sformatf("inst%0d tx_byte", i), 64'(tb), 64'(sh[7:0]));
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, bus0.rx_ready, bus0.tx_valid, bus0.tx_byte, bus0.done);
    cmp_inst(1, bus3.rx_ready, bus3.tx_valid, bus3.tx_byte, bus3.done);
  end

  // Handshake and done logs for the literal checks.
  logic [7:0] log_b [2][$];
  int         log_c [2][$];
  int         done_c [2][$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus0.tx_valid && bus0.tx_ready) begin
        log_b[0].push_back(bus0.tx_byte);
        log_c[0].push_back(cyc);
      end
      if (bus3.tx_valid && bus3.tx_ready) begin
        log_b[1].push_back(bus3.tx_byte);
        log_c[1].push_back(cyc);
      end
      if (bus0.done) done_c[0].push_back(cyc);
      if (bus3.done) done_c[1].push_back(cyc);
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      log_b[i].delete();
      log_c[i].delete();
      done_c[i].delete();
    end
  endtask

  // Expected bytes packed MSB first into exp.
  task automatic check_log(input int which, input logic [63:0] exp, input int n);
    logic [7:0] e;
    check($sformatf("log%0d length", which), 64'(log_b[which].size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      e = exp[8 * (n - 1 - k) +: 8];
      if (k < log_b[which].size())
        check($sformatf("log%0d byte %0d", which, k), 64'(log_b[which][k]), 64'(e));
    end
  endtask

  task automatic send(input int which, input logic [N-1:0] w);
    @(posedge clk); #1;
    if (which == 0) begin bus0.rx_valid = 1'b1; bus0.rx_bytes = w; end
    else begin bus3.rx_valid = 1'b1; bus3.rx_bytes = w; end
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    bus0.rx_valid = 1'b0;
    bus3.rx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " rx_ready"}, 64'(bus0.rx_ready), 64'd1);
    check({nm, " tx_valid"}, 64'(bus0.tx_valid), 64'd0);
    check({nm, " tx_byte"}, 64'(bus0.tx_byte), 64'h00);
    check({nm, " done"}, 64'(bus0.done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.rx_valid = 1'b0; bus0.rx_bytes = '0; bus0.tx_ready = 1'b0;
    bus3.rx_valid = 1'b0; bus3.rx_bytes = '0; bus3.tx_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset inst1 tx_valid", 64'(bus3.tx_valid), 64'd0);
    rst_n = 1'b1;

    // Basic word, back-to-back bytes
    bus0.tx_ready = 1'b1;
    clear_logs();
    send(0, 32'hAABBCCDD);
    repeat (8) @(posedge clk);
    #1;
    check_log(0, 64'hAABBCCDD, 4);
    if (log_b[0].size() == 4) begin
      check("basic first latency", 64'(log_c[0][0]), 64'(acc_cyc + 1));
      check("basic consecutive", 64'(log_c[0][3] - log_c[0][0]), 64'd3);
      check("basic done count", 64'(done_c[0].size()), 64'd1);
      if (done_c[0].size() == 1)
        check("basic done timing", 64'(done_c[0][0]), 64'(log_c[0][3] + 1));
    end

    // Backpressure: stall on AA, then toggle tx_ready
    bus0.tx_ready = 1'b0;
    clear_logs();
    send(0, 32'hAABBCCDD);
    repeat (5) @(posedge clk);
    #1;
    check("stall tx_valid", 64'(bus0.tx_valid), 64'd1);
    check("stall tx_byte", 64'(bus0.tx_byte), 64'hAA);
    for (int k = 0; k < 12; k++) begin
      bus0.tx_ready = (k % 2 == 0);
      @(posedge clk); #1;
    end
    bus0.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_log(0, 64'hAABBCCDD, 4);
    check("stall done count", 64'(done_c[0].size()), 64'd1);

    // GAP=3 instance
    bus3.tx_ready = 1'b1;
    clear_logs();
    send(1, 32'h11223344);
    repeat (20) @(posedge clk);
    #1;
    check_log(1, 64'h11223344, 4);
    if (log_b[1].size() == 4) begin
      check("gap first latency", 64'(log_c[1][0]), 64'(acc_cyc + 1));
      for (int k = 1; k < 4; k++)
        check($sformatf("gap spacing %0d", k), 64'(log_c[1][k] - log_c[1][k-1]), 64'd4);
      check("gap done count", 64'(done_c[1].size()), 64'd1);
      if (done_c[1].size() == 1)
        check("gap done timing", 64'(done_c[1][0]), 64'(log_c[1][3] + 1));
    end

    // Busy-ignore then back-to-back acceptance
    clear_logs();
    @(posedge clk); #1;
    bus0.rx_valid = 1'b1; bus0.rx_bytes = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus0.rx_bytes = 32'h55667788;
    repeat (5) @(posedge clk);
    #1;
    bus0.rx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_log(0, 64'hAABBCCDD55667788, 8);
    check("b2b done count", 64'(done_c[0].size()), 64'd2);
    if (log_b[0].size() == 8)
      check("b2b word gap", 64'(log_c[0][4] - log_c[0][3]), 64'd2);

    // Reset mid-word after BB
    clear_logs();
    send(0, 32'hAABBCCDD);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check_log(0, 64'hAABB, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    send(0, 32'h01020304);
    repeat (8) @(posedge clk);
    #1;
    check_log(0, 64'h01020304, 4);

    // Random traffic on both instances, checked cycle by cycle against the model
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      bus0.rx_valid = ($urandom_range(0, 3) == 0);
      bus0.rx_bytes = $urandom;
      bus0.tx_ready = $urandom_range(0, 1);
      bus3.rx_valid = ($urandom_range(0, 3) == 0);
      bus3.rx_bytes = $urandom;
      bus3.tx_ready = $urandom_range(0, 1);
    end
    bus0.rx_valid = 1'b0; bus0.tx_ready = 1'b1;
    bus3.rx_valid = 1'b0; bus3.tx_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("drain inst0 idle", 64'(bus0.rx_ready), 64'd1);
    check("drain inst1 idle", 64'(bus3.rx_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
